// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state codes, opcodes,
// ALU operation codes, mux select encodings and the control word.
// Optional feature macro: MC_JAL_EN (adds the jal instruction).
package mc_pkg;

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEM_ADDR = 4'd2;
  localparam logic [3:0] MEM_RD   = 4'd3;
  localparam logic [3:0] MEM_WB   = 4'd4;
  localparam logic [3:0] MEM_WR   = 4'd5;
  localparam logic [3:0] R_EXEC   = 4'd6;
  localparam logic [3:0] R_WB     = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] I_EXEC   = 4'd9;
  localparam logic [3:0] I_WB     = 4'd10;
  localparam logic [3:0] JUMP     = 4'd11;
  localparam logic [3:0] JAL      = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_IADD  = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCondEq;
    logic       pcWriteCondNe;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       link;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSource;
    logic       illegalOp;
  } ctrlWord_t;

  // State entered after DECODE; FETCH marks an unsupported opcode.
  function automatic logic [3:0] decodeTarget(input logic [5:0] op);
    logic [3:0] target;
    case (op)
      OP_RTYPE:                         target = R_EXEC;
      OP_LW, OP_SW:                     target = MEM_ADDR;
      OP_BEQ, OP_BNE:                   target = BRANCH;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: target = I_EXEC;
      OP_J:                             target = JUMP;
`ifdef MC_JAL_EN
      OP_JAL:                           target = JAL;
`endif
      default:                          target = FETCH;
    endcase
    return target;
  endfunction

  function automatic logic isLegalOp(input logic [5:0] op);
    return decodeTarget(op) != FETCH;
  endfunction

  // ALU operation for immediate-format instructions, held through write-back.
  function automatic logic [2:0] iTypeAluOp(input logic [5:0] op);
    logic [2:0] code;
    case (op)
      OP_ANDI: code = ALU_AND;
      OP_ORI:  code = ALU_OR;
      OP_LUI:  code = ALU_LUI;
      default: code = ALU_IADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode from the current state and opcode.
// Reset forces the whole word to zero so no strobe escapes during reset.
// Optional feature macro: MC_JAL_EN (JAL state drives the link write).
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  logic       reset,
  input  logic [3:0] state,
  input  logic [5:0] op,
  input  logic       memReady,
  output ctrlWord_t  ctrl
);

  // Moore decode; only the FETCH IR/PC loads follow the memory acknowledge.
  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state)
        FETCH: begin
          ctrl.memRead = 1'b1;
          ctrl.aluSrcB = SRCB_FOUR;
          ctrl.irWrite = memReady;
          ctrl.pcWrite = memReady;
        end
        DECODE: begin
          ctrl.aluSrcB   = SRCB_IMMSH;
          ctrl.illegalOp = !isLegalOp(op);
        end
        MEM_ADDR: begin
          ctrl.aluSrcA = 1'b1;
          ctrl.aluSrcB = SRCB_IMM;
          ctrl.aluOp   = ALU_ADD;
        end
        MEM_RD: begin
          ctrl.memRead = 1'b1;
          ctrl.iOrD    = 1'b1;
        end
        MEM_WB: begin
          ctrl.regWrite = 1'b1;
          ctrl.memToReg = 1'b1;
        end
        MEM_WR: begin
          ctrl.memWrite = 1'b1;
          ctrl.iOrD     = 1'b1;
        end
        R_EXEC: begin
          ctrl.aluSrcA = 1'b1;
          ctrl.aluSrcB = SRCB_B;
          ctrl.aluOp   = ALU_FUNCT;
        end
        R_WB: begin
          ctrl.regWrite = 1'b1;
          ctrl.regDst   = 1'b1;
        end
        BRANCH: begin
          ctrl.aluSrcA       = 1'b1;
          ctrl.aluSrcB       = SRCB_B;
          ctrl.aluOp         = ALU_SUB;
          ctrl.pcSource      = PCSRC_ALUOUT;
          ctrl.pcWriteCondEq = (op == OP_BEQ);
          ctrl.pcWriteCondNe = (op == OP_BNE);
        end
        I_EXEC: begin
          ctrl.aluSrcA = 1'b1;
          ctrl.aluSrcB = SRCB_IMM;
          ctrl.aluOp   = iTypeAluOp(op);
        end
        I_WB: begin
          ctrl.regWrite = 1'b1;
          ctrl.aluOp    = iTypeAluOp(op);
        end
        JUMP: begin
          ctrl.pcWrite  = 1'b1;
          ctrl.pcSource = PCSRC_JUMP;
        end
`ifdef MC_JAL_EN
        JAL: begin
          ctrl.pcWrite  = 1'b1;
          ctrl.pcSource = PCSRC_JUMP;
          ctrl.regWrite = 1'b1;
          ctrl.link     = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style controller: state register and next-state logic;
// the control word comes from mc_ctrl_decode.
// Optional feature macro: MC_JAL_EN (jal support; without it link stays 0
// and opcode 0x03 is reported as illegal).
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond_eq,
  output logic       pc_write_cond_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       link,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] ALUOp,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  logic [3:0] stateQ;
  logic [3:0] stateD;
  ctrlWord_t  ctrl;

  // Next state; mem_ready only matters in the three memory-wait states.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      FETCH:    if (mem_ready) stateD = DECODE;
      DECODE:   stateD = decodeTarget(OP);
      MEM_ADDR: stateD = (OP == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) stateD = MEM_WB;
      MEM_WR:   if (mem_ready) stateD = FETCH;
      R_EXEC:   stateD = R_WB;
      I_EXEC:   stateD = I_WB;
      default:  stateD = FETCH;
    endcase
  end

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) stateQ <= FETCH;
    else       stateQ <= stateD;
  end

  mc_ctrl_decode uDecode (
    .reset    (reset),
    .state    (stateQ),
    .op       (OP),
    .memReady (mem_ready),
    .ctrl     (ctrl)
  );

  assign pc_write         = ctrl.pcWrite;
  assign pc_write_cond_eq = ctrl.pcWriteCondEq;
  assign pc_write_cond_ne = ctrl.pcWriteCondNe;
  assign i_or_d           = ctrl.iOrD;
  assign mem_read         = ctrl.memRead;
  assign mem_write        = ctrl.memWrite;
  assign ir_write         = ctrl.irWrite;
  assign reg_dst          = ctrl.regDst;
  assign mem_to_reg       = ctrl.memToReg;
  assign reg_write        = ctrl.regWrite;
  assign link             = ctrl.link;
  assign alu_src_a        = ctrl.aluSrcA;
  assign alu_src_b        = ctrl.aluSrcB;
  assign ALUOp            = ctrl.aluOp;
  assign pc_source        = ctrl.pcSource;
  assign illegal_op       = ctrl.illegalOp;
  // Debug state reads zero while reset is held, like every other output.
  assign state            = reset ? FETCH : stateQ;

endmodule
